// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Desc    : Oversampling serial receiver feeding a first-word-fall-through FIFO.
//           Define UART_RX_PARITY_EN to build the parity state and checker.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_DIV    = 106,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ser_rx,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             frame_err,
    output logic                             parity_err,
    output logic                             overrun
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [15:0]        c_HALF     = 16'(CLK_DIV >> 1);
    localparam logic [15:0]        c_FULL     = 16'(CLK_DIV);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_LVL_W-1:0] c_DEPTH    = c_LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PAR       = 3'd3;
    localparam logic [2:0] c_STOP      = 3'd4;
    localparam logic [2:0] c_WAIT_HIGH = 3'd5;

    logic                 r_sync1, r_rx_s, r_rx_prev;
    logic [2:0]           r_state;
    logic [15:0]          r_cnt;
    logic [c_BIT_W-1:0]   r_bits;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_frame_err, r_overrun;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 w_tick, w_fall, w_stop_tick, w_good;
    logic                 w_pop, w_full, w_push, w_par_bad;

    assign w_tick      = (r_cnt == 16'd1);
    assign w_fall      = r_rx_prev && !r_rx_s;
    assign w_stop_tick = (r_state == c_STOP) && w_tick;

`ifdef UART_RX_PARITY_EN
    localparam bit c_PAR_ON = (PARITY == 1) || (PARITY == 2);

    logic r_par_bad, r_parity_err, w_par_exp;

    // Expected parity bit: even -> XOR of data, odd -> XNOR of data.
    assign w_par_exp = (PARITY == 2) ? ^r_shreg : ~^r_shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_stop_tick && r_rx_s && r_par_bad;
            if (r_state == c_IDLE)
                r_par_bad <= 1'b0;
            else if (r_state == c_PAR && w_tick)
                r_par_bad <= (r_rx_s != w_par_exp);
        end
    end

    assign w_par_bad  = r_par_bad;
    assign parity_err = r_parity_err;
`else
    // Checker not built: PARITY has no effect on the frame format.
    localparam bit c_PAR_ON = 1'b0 && (PARITY != 0);

    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= c_IDLE;
            r_cnt     <= c_HALF;
            r_bits    <= '0;
            r_shreg   <= '0;
        end else begin
            r_sync1   <= ser_rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            // Idle preloads the half-bit delay so the start sample lands mid-bit.
            if (r_state == c_IDLE)
                r_cnt <= c_HALF;
            else if (w_tick)
                r_cnt <= c_FULL;
            else
                r_cnt <= r_cnt - 16'd1;
            case (r_state)
                c_IDLE:  if (w_fall) r_state <= c_START;
                c_START: if (w_tick) begin
                    r_bits  <= '0;
                    r_state <= r_rx_s ? c_IDLE : c_DATA;
                end
                c_DATA: if (w_tick) begin
                    r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                    r_bits  <= r_bits + 1'b1;
                    if (r_bits == c_LAST_BIT)
                        r_state <= c_PAR_ON ? c_PAR : c_STOP;
                end
                c_PAR:       if (w_tick) r_state <= c_STOP;
                c_STOP:      if (w_tick) r_state <= r_rx_s ? c_IDLE : c_WAIT_HIGH;
                c_WAIT_HIGH: if (r_rx_s) r_state <= c_IDLE;
                default:     r_state <= c_IDLE;
            endcase
        end
    end

    // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts.
    assign w_good = w_stop_tick && r_rx_s && !w_par_bad;
    assign w_pop  = rx_valid && rx_ready;
    assign w_full = (r_level == c_DEPTH);
    assign w_push = w_good && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_frame_err <= w_stop_tick && !r_rx_s;
            r_overrun   <= w_good && w_full && !w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_push && w_pop)
                r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shreg;
    end

    assign rx_valid   = (r_level != '0);
    assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
